// File: rtl/imem_loader.sv
// Byte-stream loader for the instruction ROM: assembles big-endian words and writes them from BASE_ADDR up.
// Optional trailing XOR checksum byte enabled by defining IMEM_LOADER_CHECKSUM_EN.
module imem_loader #(
  parameter logic [31:0] BASE_ADDR = 32'h3000,
  parameter int          DEPTH     = 1024
) (
  input  logic        clk,
  input  logic        Reset_n,
  input  logic        Load_Start,
  input  logic [7:0]  Byte_In,
  input  logic        Byte_Valid,
  output logic        Byte_Ready,
  output logic        Mem_WE,
  output logic [31:0] Mem_Addr,
  output logic [31:0] Mem_WData,
  output logic        CPU_Hold,
  output logic        Busy,
  output logic        Done,
  output logic        Load_Err,
  output logic [15:0] Words_Loaded
);

  localparam logic [15:0] DEPTH_W = 16'(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CNT_HI,
    S_CNT_LO,
    S_DATA,
`ifdef IMEM_LOADER_CHECKSUM_EN
    S_CHK,
`endif
    S_DONE,
    S_ERR
  } state_t;

  state_t      state_q, state_nxt;
  logic [15:0] cnt_q, cnt_nxt;
  logic [15:0] words_q, words_nxt;
  logic [1:0]  idx_q, idx_nxt;
  logic [23:0] shift_q, shift_nxt;
  logic        we_q, we_nxt;
  logic [31:0] addr_q, addr_nxt;
  logic [31:0] wdata_q, wdata_nxt;
  logic        ready_q, ready_nxt;
  logic        hold_q, hold_nxt;
  logic        busy_q, busy_nxt;
  logic        done_q, done_nxt;
  logic        err_q, err_nxt;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]  xor_q, xor_nxt;
`endif

  logic        accept;
  logic [15:0] cnt_full;
  logic [15:0] words_inc;

  assign accept    = Byte_Valid && ready_q;
  assign cnt_full  = {cnt_q[15:8], Byte_In};
  assign words_inc = words_q + 16'd1;

  always_ff @(posedge clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      words_q <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      ready_q <= 1'b0;
      hold_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      xor_q   <= '0;
`endif
    end else begin
      state_q <= state_nxt;
      cnt_q   <= cnt_nxt;
      words_q <= words_nxt;
      idx_q   <= idx_nxt;
      shift_q <= shift_nxt;
      we_q    <= we_nxt;
      addr_q  <= addr_nxt;
      wdata_q <= wdata_nxt;
      ready_q <= ready_nxt;
      hold_q  <= hold_nxt;
      busy_q  <= busy_nxt;
      done_q  <= done_nxt;
      err_q   <= err_nxt;
`ifdef IMEM_LOADER_CHECKSUM_EN
      xor_q   <= xor_nxt;
`endif
    end
  end

  always_comb begin
    state_nxt = state_q;
    cnt_nxt   = cnt_q;
    words_nxt = words_q;
    idx_nxt   = idx_q;
    shift_nxt = shift_q;
    we_nxt    = 1'b0;
    addr_nxt  = addr_q;
    wdata_nxt = wdata_q;
    ready_nxt = ready_q;
    hold_nxt  = hold_q;
    busy_nxt  = busy_q;
    done_nxt  = 1'b0;
    err_nxt   = err_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
    xor_nxt   = xor_q;
`endif

    if ((state_q == S_IDLE || state_q == S_ERR) && Load_Start) begin
      state_nxt = S_CNT_HI;
      cnt_nxt   = '0;
      words_nxt = '0;
      idx_nxt   = '0;
      shift_nxt = '0;
      ready_nxt = 1'b1;
      hold_nxt  = 1'b1;
      busy_nxt  = 1'b1;
      err_nxt   = 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      xor_nxt   = '0;
`endif
    end else begin
      case (state_q)
        S_CNT_HI: begin
          if (accept) begin
            cnt_nxt   = {Byte_In, 8'h00};
            state_nxt = S_CNT_LO;
          end
        end
        S_CNT_LO: begin
          if (accept) begin
            cnt_nxt = cnt_full;
            if (cnt_full > DEPTH_W) begin
              state_nxt = S_ERR;
              ready_nxt = 1'b0;
              busy_nxt  = 1'b0;
              err_nxt   = 1'b1;
            end else if (cnt_full == 16'd0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
              state_nxt = S_CHK;
`else
              state_nxt = S_DONE;
              ready_nxt = 1'b0;
              done_nxt  = 1'b1;
`endif
            end else begin
              state_nxt = S_DATA;
            end
          end
        end
        S_DATA: begin
          if (accept) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
            xor_nxt = xor_q ^ Byte_In;
`endif
            if (idx_q == 2'd3) begin
              we_nxt    = 1'b1;
              wdata_nxt = {shift_q, Byte_In};
              addr_nxt  = BASE_ADDR + {14'd0, words_q, 2'b00};
              words_nxt = words_inc;
              idx_nxt   = 2'd0;
              // Stop taking bytes while the final word is written; the exit happens next cycle.
              if (words_inc == cnt_q) ready_nxt = 1'b0;
            end else begin
              shift_nxt = {shift_q[15:0], Byte_In};
              idx_nxt   = idx_q + 2'd1;
            end
          end else if (we_q && words_q == cnt_q) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
            state_nxt = S_CHK;
            ready_nxt = 1'b1;
`else
            state_nxt = S_DONE;
            done_nxt  = 1'b1;
`endif
          end
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        S_CHK: begin
          if (accept) begin
            ready_nxt = 1'b0;
            if (Byte_In == xor_q) begin
              state_nxt = S_DONE;
              done_nxt  = 1'b1;
            end else begin
              state_nxt = S_ERR;
              busy_nxt  = 1'b0;
              err_nxt   = 1'b1;
            end
          end
        end
`endif
        S_DONE: begin
          state_nxt = S_IDLE;
          busy_nxt  = 1'b0;
          hold_nxt  = 1'b0;
        end
        S_ERR:   state_nxt = S_ERR;
        S_IDLE:  state_nxt = S_IDLE;
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  assign Byte_Ready   = ready_q;
  assign Mem_WE       = we_q;
  assign Mem_Addr     = addr_q;
  assign Mem_WData    = wdata_q;
  assign CPU_Hold     = hold_q;
  assign Busy         = busy_q;
  assign Done         = done_q;
  assign Load_Err     = err_q;
  assign Words_Loaded = words_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: cycle table for the basic load plus hand sequences for corner cases.
module tb_imem_loader;

  logic        clk;
  logic        Reset_n;
  logic        Load_Start;
  logic [7:0]  Byte_In;
  logic        Byte_Valid;
  logic        Byte_Ready;
  logic        Mem_WE;
  logic [31:0] Mem_Addr;
  logic [31:0] Mem_WData;
  logic        CPU_Hold;
  logic        Busy;
  logic        Done;
  logic        Load_Err;
  logic [15:0] Words_Loaded;

  imem_loader #(.BASE_ADDR(32'h3000), .DEPTH(1024)) dut (
    .clk(clk), .Reset_n(Reset_n), .Load_Start(Load_Start), .Byte_In(Byte_In),
    .Byte_Valid(Byte_Valid), .Byte_Ready(Byte_Ready), .Mem_WE(Mem_WE),
    .Mem_Addr(Mem_Addr), .Mem_WData(Mem_WData), .CPU_Hold(CPU_Hold), .Busy(Busy),
    .Done(Done), .Load_Err(Load_Err), .Words_Loaded(Words_Loaded)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        ls;
    logic        v;
    logic [7:0]  b;
    logic        rdy;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        hold;
    logic        busy;
    logic        done;
    logic        err;
    logic [15:0] wl;
  } vec_t;

  vec_t tbl[$];

  int          vec_cnt = 0;
  int          err_cnt = 0;
  int          wr_cnt, done_cnt;
  logic [31:0] wr_addr [8];
  logic [31:0] wr_data [8];
  logic        hold_at_done, hold_after_done, prev_done;
  logic [15:0] wl_at_done;

  function automatic vec_t mk(input logic ls, v, input logic [7:0] b, input logic rdy, we,
                              input logic [31:0] addr, wdata, input logic hold, busy, done, err,
                              input logic [15:0] wl);
    vec_t r;
    r.ls = ls; r.v = v; r.b = b; r.rdy = rdy; r.we = we; r.addr = addr; r.wdata = wdata;
    r.hold = hold; r.busy = busy; r.done = done; r.err = err; r.wl = wl;
    return r;
  endfunction

  function automatic logic [95:0] outs();
    return {10'd0, Byte_Ready, Mem_WE, Mem_Addr, Mem_WData, CPU_Hold, Busy, Done, Load_Err, Words_Loaded};
  endfunction

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic clear_log();
    wr_cnt = 0; done_cnt = 0; prev_done = 0;
    hold_at_done = 1'bx; hold_after_done = 1'bx; wl_at_done = 16'hxxxx;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if (Mem_WE && wr_cnt < 8) begin
      wr_addr[wr_cnt] = Mem_Addr;
      wr_data[wr_cnt] = Mem_WData;
      wr_cnt++;
    end
    if (prev_done) hold_after_done = CPU_Hold;
    if (Done) begin
      done_cnt++;
      hold_at_done = CPU_Hold;
      wl_at_done   = Words_Loaded;
    end
    prev_done = Done;
  endtask

  task automatic start();
    Load_Start = 1'b1;
    step();
    Load_Start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int t;
    t = 0;
    Byte_In = b;
    Byte_Valid = 1'b1;
    while (!Byte_Ready && t < 20) begin
      step();
      t++;
    end
    if (!Byte_Ready) check("byte_ready_timeout", 96'(Byte_Ready), 96'd1);
    step();
    Byte_Valid = 1'b0;
    repeat (gap) step();
  endtask

  task automatic chk_tail(input logic [7:0] b);
`ifdef IMEM_LOADER_CHECKSUM_EN
    send_byte(b, 0);
`else
    if (b === 8'hxx) step();
`endif
  endtask

  task automatic wait_done();
    int t;
    t = 0;
    while (done_cnt == 0 && t < 20) begin
      step();
      t++;
    end
    step();
    step();
  endtask

  logic [7:0] stream [10];

  initial begin
    stream = '{8'h00, 8'h02, 8'h24, 8'h08, 8'h00, 8'h05, 8'hAC, 8'h08, 8'h00, 8'h00};

    // basic load, one row per clock: inputs applied, outputs after the edge
    tbl.push_back(mk(1,0,8'h00, 1,0,32'h0,32'h0, 1,1,0,0,16'd0));
    tbl.push_back(mk(0,1,8'h00, 1,0,32'h0,32'h0, 1,1,0,0,16'd0));
    tbl.push_back(mk(0,1,8'h02, 1,0,32'h0,32'h0, 1,1,0,0,16'd0));
    tbl.push_back(mk(0,1,8'h24, 1,0,32'h0,32'h0, 1,1,0,0,16'd0));
    tbl.push_back(mk(0,1,8'h08, 1,0,32'h0,32'h0, 1,1,0,0,16'd0));
    tbl.push_back(mk(0,1,8'h00, 1,0,32'h0,32'h0, 1,1,0,0,16'd0));
    tbl.push_back(mk(0,1,8'h05, 1,1,32'h3000,32'h24080005, 1,1,0,0,16'd1));
    tbl.push_back(mk(0,1,8'hAC, 1,0,32'h3000,32'h24080005, 1,1,0,0,16'd1));
    tbl.push_back(mk(0,1,8'h08, 1,0,32'h3000,32'h24080005, 1,1,0,0,16'd1));
    tbl.push_back(mk(0,1,8'h00, 1,0,32'h3000,32'h24080005, 1,1,0,0,16'd1));
    tbl.push_back(mk(0,1,8'h00, 0,1,32'h3004,32'hAC080000, 1,1,0,0,16'd2));
`ifdef IMEM_LOADER_CHECKSUM_EN
    tbl.push_back(mk(0,0,8'h00, 1,0,32'h3004,32'hAC080000, 1,1,0,0,16'd2));
    tbl.push_back(mk(0,1,8'h8D, 0,0,32'h3004,32'hAC080000, 1,1,1,0,16'd2));
`else
    tbl.push_back(mk(0,0,8'h00, 0,0,32'h3004,32'hAC080000, 1,1,1,0,16'd2));
`endif
    tbl.push_back(mk(0,0,8'h00, 0,0,32'h3004,32'hAC080000, 0,0,0,0,16'd2));
    tbl.push_back(mk(0,0,8'h00, 0,0,32'h3004,32'hAC080000, 0,0,0,0,16'd2));

    Reset_n = 1'b0; Load_Start = 1'b0; Byte_In = 8'h00; Byte_Valid = 1'b0;
    clear_log();
    #12;
    check("reset_outputs", outs(), 96'd0);
    @(negedge clk);
    Reset_n = 1'b1;

    // cycle table
    foreach (tbl[i]) begin
      vec_t r;
      r = tbl[i];
      Load_Start = r.ls; Byte_Valid = r.v; Byte_In = r.b;
      step();
      check($sformatf("basic_row%0d", i), outs(),
            {10'd0, r.rdy, r.we, r.addr, r.wdata, r.hold, r.busy, r.done, r.err, r.wl});
    end
    Load_Start = 1'b0; Byte_Valid = 1'b0;

    // back-pressure, with a Load_Start pulse mid-session that must be ignored
    clear_log();
    start();
    for (int i = 0; i < 10; i++) begin
      send_byte(stream[i], 0);
      if (i == 4) begin
        Load_Start = 1'b1; step(); Load_Start = 1'b0; step(); step();
      end else begin
        repeat (3) step();
      end
    end
`ifdef IMEM_LOADER_CHECKSUM_EN
    send_byte(8'h8D, 3);
`endif
    wait_done();
    check("bp_wr_cnt", 96'(wr_cnt), 96'd2);
    check("bp_addr0", 96'(wr_addr[0]), 96'h3000);
    check("bp_data0", 96'(wr_data[0]), 96'h24080005);
    check("bp_addr1", 96'(wr_addr[1]), 96'h3004);
    check("bp_data1", 96'(wr_data[1]), 96'hAC080000);
    check("bp_done_cnt", 96'(done_cnt), 96'd1);
    check("bp_words_at_done", 96'(wl_at_done), 96'd2);
    check("bp_hold_at_done", 96'(hold_at_done), 96'd1);
    check("bp_hold_after_done", 96'(hold_after_done), 96'd0);

    // zero count
    clear_log();
    start();
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    chk_tail(8'h00);
    wait_done();
    check("zero_wr_cnt", 96'(wr_cnt), 96'd0);
    check("zero_done_cnt", 96'(done_cnt), 96'd1);
    check("zero_words", 96'(wl_at_done), 96'd0);

    // oversize count 1025, then recovery with a fresh session
    clear_log();
    start();
    send_byte(8'h04, 0);
    send_byte(8'h01, 0);
    Byte_In = 8'h11; Byte_Valid = 1'b1;
    step(); step();
    Byte_Valid = 1'b0;
    check("over_state", {92'd0, Load_Err, CPU_Hold, Byte_Ready, Busy}, {92'd0, 4'b1100});
    check("over_wr_cnt", 96'(wr_cnt), 96'd0);
    check("over_done_cnt", 96'(done_cnt), 96'd0);
    start();
    check("over_restart", {92'd0, Load_Err, CPU_Hold, Byte_Ready, Busy}, {92'd0, 4'b0111});
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    chk_tail(8'h00);
    wait_done();
    check("over_recover_done", 96'(done_cnt), 96'd1);

    // reset after six data bytes
    clear_log();
    start();
    for (int i = 0; i < 8; i++) send_byte(stream[i], 0);
    #2 Reset_n = 1'b0;
    #1 check("rst_async_outputs", outs(), 96'd0);
    check("rst_wr_cnt", 96'(wr_cnt), 96'd1);
    check("rst_wr_addr", 96'(wr_addr[0]), 96'h3000);
    check("rst_wr_data", 96'(wr_data[0]), 96'h24080005);
    #2 Reset_n = 1'b1;
    step(); step();
    check("rst_idle_outputs", outs(), 96'd0);

`ifdef IMEM_LOADER_CHECKSUM_EN
    // checksum good and bad
    clear_log();
    start();
    send_byte(8'h00, 0); send_byte(8'h01, 0);
    send_byte(8'h12, 0); send_byte(8'h34, 0); send_byte(8'h56, 0); send_byte(8'h78, 0);
    send_byte(8'h08, 0);
    wait_done();
    check("ck_good_wr_cnt", 96'(wr_cnt), 96'd1);
    check("ck_good_data", 96'(wr_data[0]), 96'h12345678);
    check("ck_good_done", 96'(done_cnt), 96'd1);
    clear_log();
    start();
    send_byte(8'h00, 0); send_byte(8'h01, 0);
    send_byte(8'h12, 0); send_byte(8'h34, 0); send_byte(8'h56, 0); send_byte(8'h78, 0);
    send_byte(8'h09, 0);
    step(); step();
    check("ck_bad_wr_cnt", 96'(wr_cnt), 96'd1);
    check("ck_bad_err", {94'd0, Load_Err, CPU_Hold}, {94'd0, 2'b11});
    check("ck_bad_done", 96'(done_cnt), 96'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
Writer side of the instruction ROM: receives a program as a byte stream over a valid/ready handshake, assembles big-endian 32-bit words and writes them into instruction memory starting at the reset PC.
Holds the CPU in reset while loading, so fetch resumes at BASE_ADDR with the new image.
Sits between the host/debug byte link and the instruction memory write port.

Parameters:
BASE_ADDR, 32'h3000, byte address of first written word (reset PC)
DEPTH, 1024, instruction memory capacity in words; max accepted word count

Ports:
clk  input  1  system clock, rising edge
Reset_n  input  1  asynchronous, active-low reset
Load_Start  input  1  one-cycle pulse; begins a load session
Byte_In  input  8  stream byte
Byte_Valid  input  1  Byte_In valid
Byte_Ready  output  1  loader can accept a byte
Mem_WE  output  1  instruction memory write strobe, one cycle per word
Mem_Addr  output  32  byte address of word being written
Mem_WData  output  32  word being written
CPU_Hold  output  1  keep CPU/fetch unit in reset
Busy  output  1  session in progress
Done  output  1  one-cycle pulse on successful completion
Load_Err  output  1  sticky error flag
Words_Loaded  output  16  count of words written this session

Behaviour:
- Reset (async, Reset_n=0): state IDLE; all outputs 0; Words_Loaded=0; internal counters/shift register cleared.
- Byte accepted only on a cycle with Byte_Valid && Byte_Ready; Byte_Ready is registered and is 1 only in CNT_HI, CNT_LO, DATA, CHK.
- States:
  - IDLE: Load_Start -> CNT_HI. On that edge: CPU_Hold=1, Busy=1, Load_Err=0, Words_Loaded=0, byte index=0.
  - CNT_HI: accept byte -> N[15:8]; -> CNT_LO.
  - CNT_LO: accept byte -> N[7:0]. Then:
    - N>DEPTH: -> ERR.
    - N==0: -> CHK if CHECKSUM_EN, else DONE.
    - Otherwise: -> DATA.
  - DATA: bytes shifted in MSB first. On the 4th byte of a word, the next cycle drives:
    - Mem_WE=1 for exactly one cycle.
    - Mem_WData = assembled word.
    - Mem_Addr = BASE_ADDR + 4*word_index.
    - Words_Loaded incremented in the same cycle.
    - After word N: -> CHK if CHECKSUM_EN, else DONE.
  - DONE: Done=1 for one cycle; Busy=0 and CPU_Hold=0 on the following edge; -> IDLE.
  - ERR: Load_Err=1, Busy=0, CPU_Hold stays 1, Byte_Ready=0. Exit only via Load_Start (restarts at CNT_HI) or reset.
- Mem_WE is never asserted in CNT_HI, CNT_LO, CHK or ERR. At most one write every 4 accepted bytes.
- Mem_Addr and Mem_WData hold their last value when Mem_WE=0.
- Load_Start while Busy=1: ignored.
- Load_Start in the same cycle as a byte in IDLE: the byte is not consumed.
- Byte_Valid gaps: state and partial word hold indefinitely; no timeout.
- Address width: word_index is 10 bits for DEPTH 1024. BASE_ADDR + 4*(DEPTH-1) is the last write; no wrap.
- Reset mid-session: immediate abort to IDLE with outputs 0. Words already written remain in memory.

Optional Feature:
Macro: IMEM_LOADER_CHECKSUM_EN.
- Defined:
  - Running XOR of all data bytes (count bytes excluded), cleared at Load_Start.
  - CHK state accepts one trailing byte.
  - If it equals the XOR: -> DONE.
  - If not: -> ERR. Words already written remain; Done not pulsed.
- Not defined: no CHK state, no trailing byte; DATA/CNT_LO go directly to DONE.

Test Plan:
- Basic load: Load_Start, bytes 00 02 24 08 00 05 AC 08 00 00 -> two Mem_WE pulses:
  - 0x00003000 <= 0x24080005
  - 0x00003004 <= 0xAC080000
  - then Done pulse, Words_Loaded=2, CPU_Hold falls the cycle after Done.
- Back-pressure: same stream with Byte_Valid low 3 cycles between each byte -> identical writes/addresses, no extra Mem_WE.
- Zero count: bytes 00 00 -> no Mem_WE, Done pulse, Words_Loaded=0.
- Oversize: bytes 04 01 (N=1025) -> no Mem_WE, Load_Err=1, CPU_Hold=1, Byte_Ready=0. A new Load_Start clears Load_Err and accepts a fresh count.
- Reset mid-load: assert Reset_n=0 after 6 data bytes -> all outputs 0 asynchronously, exactly one word written (0x3000), state IDLE after release.
- With IMEM_LOADER_CHECKSUM_EN: 00 01 12 34 56 78 08 -> write 0x3000 <= 0x12345678, Done pulse. Trailing byte 09 instead -> write occurs, Load_Err=1, no Done.
